// File: rtl/csr_counter_unit.sv
// csr_counter_unit: 64-bit cycle/instret performance counters with CSR read and read-modify-write access
module csr_counter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        retired,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid
);
    logic [63:0] cycle_q, cycle_d, instret_q, instret_d;
    logic [31:0] rdata_q, rdata_d, old_val, new_val;
    logic        valid_q, valid_d, mapped, modifying, wr;

    always_comb begin
        mapped = 1'b1;
        old_val = '0;
        case (addr)
            12'hB00, 12'hC00, 12'hC01: old_val = cycle_q[31:0];
            12'hB80, 12'hC80, 12'hC81: old_val = cycle_q[63:32];
            12'hB02, 12'hC02:          old_val = instret_q[31:0];
            12'hB82, 12'hC82:          old_val = instret_q[63:32];
            default:                   mapped = 1'b0;
        endcase
        modifying = modify != 3'b000;
        // user-level (11xx) CSRs are read-only, so any modify there is rejected outright
        valid_d = (read | modifying) & mapped & ~(modifying & (addr[11:10] == 2'b11));
        rdata_d = valid_d ? old_val : '0;
        new_val = modify == 3'b001 ? wdata :
                  modify == 3'b010 ? old_val | wdata : old_val & ~wdata;
        wr = valid_d & modifying & ~modify[2];
        cycle_d = cycle_q + 64'd1;
        instret_d = instret_q + {63'd0, retired};
        // a write to either half replaces the increment for that counter this cycle
        if (wr) begin
            case (addr)
                12'hB00: cycle_d = {cycle_q[63:32], new_val};
                12'hB80: cycle_d = {new_val, cycle_q[31:0]};
                12'hB02: instret_d = {instret_q[63:32], new_val};
                12'hB82: instret_d = {new_val, instret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q   <= '0;
            instret_q <= '0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
            rdata_q   <= rdata_d;
            valid_q   <= valid_d;
        end
    end

    assign rdata = rdata_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_csr_counter_unit.sv
// tb_csr_counter_unit: scoreboard bench with a reference model of the counters and CSR map
module tb_csr_counter_unit;
    logic        clk = 1'b0;
    logic        rst, retired, read;
    logic [2:0]  modify;
    logic [31:0] wdata, rdata;
    logic [11:0] addr;
    logic        valid;

    typedef struct {
        logic        v;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [63:0] m_cyc = '0;
    logic [63:0] m_ins = '0;

    csr_counter_unit dut (
        .clk(clk), .rst(rst), .retired(retired), .read(read), .modify(modify),
        .wdata(wdata), .addr(addr), .rdata(rdata), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic r, input logic ret, input logic rd, input logic [2:0] op,
                         input logic [11:0] a, input logic [31:0] wd, input string tag);
        exp_t        e;
        logic        hit, ok, wr;
        logic [31:0] old, nv;
        logic [63:0] nc, ni;
        rst = r; retired = ret; read = rd; modify = op; addr = a; wdata = wd;
        hit = 1'b1;
        old = '0;
        case (a)
            12'hB00, 12'hC00, 12'hC01: old = m_cyc[31:0];
            12'hB80, 12'hC80, 12'hC81: old = m_cyc[63:32];
            12'hB02, 12'hC02:          old = m_ins[31:0];
            12'hB82, 12'hC82:          old = m_ins[63:32];
            default:                   hit = 1'b0;
        endcase
        ok = !r && (rd || op != 3'd0) && hit && !(op != 3'd0 && a[11:8] >= 4'hC);
        e.v = ok;
        e.d = ok ? old : 32'd0;
        sb.push_back(e);
        nv = (op == 3'd1) ? wd : (op == 3'd2) ? (old | wd) : (old & ~wd);
        wr = ok && op >= 3'd1 && op <= 3'd3;
        nc = m_cyc + 64'd1;
        ni = ret ? m_ins + 64'd1 : m_ins;
        if (wr && a == 12'hB00) nc = {m_cyc[63:32], nv};
        if (wr && a == 12'hB80) nc = {nv, m_cyc[31:0]};
        if (wr && a == 12'hB02) ni = {m_ins[63:32], nv};
        if (wr && a == 12'hB82) ni = {nv, m_ins[31:0]};
        m_cyc = r ? 64'd0 : nc;
        m_ins = r ? 64'd0 : ni;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, e.v});
        check({tag, ".rdata"}, rdata, e.d);
    endtask

    logic [11:0] alist [12] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'h7C0, 12'hB01};

    initial begin
        for (int k = 0; k < 4; k++) issue(1, 0, 0, 0, 12'h000, 0, "reset");
        for (int k = 0; k < 10; k++) issue(0, 0, 0, 0, 12'h000, 0, "idle");
        issue(0, 0, 1, 0, 12'hB00, 0, "mcycle_rd");
        check("cycle_is_10", rdata, 32'd10);
        for (int k = 0; k < 5; k++) issue(0, 1, 0, 0, 12'h000, 0, "retire");
        issue(0, 0, 1, 0, 12'hC02, 0, "instret_lo");
        check("instret_is_5", rdata, 32'd5);
        issue(0, 0, 1, 0, 12'hC82, 0, "instret_hi");
        check("instret_hi_0", rdata, 32'd0);
        issue(0, 0, 0, 1, 12'hB00, 32'hFFFF_FFFE, "wr_lo");
        issue(0, 0, 1, 0, 12'hB00, 0, "carry0");
        check("held_after_wr", rdata, 32'hFFFF_FFFE);
        issue(0, 0, 1, 0, 12'hB00, 0, "carry1");
        check("lo_all_ones", rdata, 32'hFFFF_FFFF);
        issue(0, 0, 1, 0, 12'hB00, 0, "carry2");
        check("lo_wrapped", rdata, 32'd0);
        issue(0, 0, 1, 0, 12'hB80, 0, "carry_hi");
        check("hi_carried", rdata, 32'd1);
        issue(0, 0, 0, 1, 12'hB02, 32'h0000_00F0, "ins_wr");
        issue(0, 0, 1, 2, 12'hB02, 32'h0000_000F, "ins_set");
        check("set_old", rdata, 32'h0000_00F0);
        issue(0, 0, 1, 3, 12'hB02, 32'h0000_0030, "ins_clr");
        check("clr_old", rdata, 32'h0000_00FF);
        issue(0, 1, 1, 0, 12'hC02, 0, "ins_final");
        check("final_cf", rdata, 32'h0000_00CF);
        issue(0, 0, 0, 1, 12'hC00, 32'h1234_5678, "ro_wr");
        check("ro_wr_invalid", {31'd0, valid}, 32'd0);
        issue(0, 0, 1, 0, 12'h7C0, 0, "unmapped_rd");
        issue(0, 0, 1, 2, 12'h7C0, 32'hFFFF_FFFF, "unmapped_set");
        issue(0, 0, 1, 0, 12'hC01, 0, "time_alias");
        issue(1, 0, 0, 1, 12'hB00, 32'h0000_1234, "mid_rst");
        check("mid_rst_invalid", {31'd0, valid}, 32'd0);
        issue(0, 0, 1, 0, 12'hB00, 0, "post_rst");
        check("post_rst_zero", rdata, 32'd0);
        for (int k = 0; k < 300; k++)
            issue(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  alist[$urandom_range(0, 11)], $urandom, "rand");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
